// File: rtl/hamiltonian_term_builder.sv
// Walks every site pair (i <= j) of a captured per-site charge structure and
// streams one Hamiltonian term for each pair whose two charges are both nonzero.
module hamiltonian_term_builder #(
    parameter int N_SITES = 8,
    parameter int Z_W     = 8,
    parameter int IDX_W   = $clog2(N_SITES),
    parameter int COEF_W  = 2 * Z_W,
    parameter int CNT_W   = $clog2(N_SITES * (N_SITES + 1) / 2 + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SITES*Z_W-1:0] molecular_structure,
    input  logic                   struct_valid,
    output logic                   struct_ready,
    output logic                   term_valid,
    input  logic                   term_ready,
    output logic [IDX_W-1:0]       term_i,
    output logic [IDX_W-1:0]       term_j,
    output logic [COEF_W-1:0]      term_coef,
    output logic [CNT_W-1:0]       term_count,
    output logic                   hamiltonian_ready,
    output logic                   empty_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SITES - 1);

    state_t                   state_r;
    logic [N_SITES*Z_W-1:0]   zs_r;
    logic [IDX_W-1:0]         i_r;
    logic [IDX_W-1:0]         j_r;

    logic                     accept_s;
    logic                     all_zero_s;
    logic                     last_s;
    logic                     stall_s;
    logic [N_SITES*Z_W-1:0]   src_s;
    logic [IDX_W-1:0]         ni_s;
    logic [IDX_W-1:0]         nj_s;
    logic [Z_W-1:0]           zi_s;
    logic [Z_W-1:0]           zj_s;
    logic                     emit_s;
    logic [COEF_W-1:0]        coef_s;

    function automatic logic [Z_W-1:0] site_field(input logic [N_SITES*Z_W-1:0] s,
                                                  input logic [IDX_W-1:0] idx);
        return s[int'(idx)*Z_W +: Z_W];
    endfunction

    // Next candidate pair and its term, taken from the incoming structure on acceptance.
    always_comb begin
        accept_s   = struct_valid && struct_ready;
        all_zero_s = (molecular_structure == '0);
        last_s     = (i_r == LAST_IDX) && (j_r == LAST_IDX);
        stall_s    = term_valid && !term_ready;
        src_s      = accept_s ? molecular_structure : zs_r;
        ni_s       = i_r;
        nj_s       = j_r;
        if (accept_s) begin
            ni_s = '0;
            nj_s = '0;
        end else if (j_r == LAST_IDX) begin
            ni_s = i_r + IDX_W'(1);
            nj_s = i_r + IDX_W'(1);
        end else begin
            ni_s = i_r;
            nj_s = j_r + IDX_W'(1);
        end
        zi_s   = site_field(src_s, ni_s);
        zj_s   = site_field(src_s, nj_s);
        emit_s = (zi_s != '0) && (zj_s != '0);
        if (ni_s == nj_s) begin
            coef_s = COEF_W'(zi_s);
        end else begin
            coef_s = COEF_W'(zi_s) * COEF_W'(zj_s);
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            zs_r              <= '0;
            i_r               <= '0;
            j_r               <= '0;
            struct_ready      <= 1'b1;
            term_valid        <= 1'b0;
            term_i            <= '0;
            term_j            <= '0;
            term_coef         <= '0;
            term_count        <= '0;
            hamiltonian_ready <= 1'b0;
            empty_err         <= 1'b0;
        end else begin
            empty_err <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        zs_r              <= molecular_structure;
                        term_count        <= '0;
                        hamiltonian_ready <= 1'b0;
                        i_r               <= '0;
                        j_r               <= '0;
                        if (all_zero_s) begin
                            state_r    <= IDLE;
                            empty_err  <= 1'b1;
                            term_valid <= 1'b0;
                        end else begin
                            state_r      <= SCAN;
                            struct_ready <= 1'b0;
                            term_valid   <= emit_s;
                            term_i       <= ni_s;
                            term_j       <= nj_s;
                            term_coef    <= coef_s;
                        end
                    end
                end
                SCAN: begin
                    // A presented term holds until taken; skipped candidates advance every cycle.
                    if (!stall_s) begin
                        if (term_valid) begin
                            term_count <= term_count + CNT_W'(1);
                        end
                        if (last_s) begin
                            state_r           <= DONE;
                            struct_ready      <= 1'b1;
                            hamiltonian_ready <= 1'b1;
                            term_valid        <= 1'b0;
                        end else begin
                            i_r        <= ni_s;
                            j_r        <= nj_s;
                            term_valid <= emit_s;
                            term_i     <= ni_s;
                            term_j     <= nj_s;
                            term_coef  <= coef_s;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    struct_ready <= 1'b1;
                    term_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamiltonian_term_builder.sv
// Self-checking bench for hamiltonian_term_builder (N_SITES=4) against a
// pair-enumeration reference model with randomized structures and back-pressure.
module tb_hamiltonian_term_builder;

    localparam int N  = 4;
    localparam int ZW = 8;
    localparam int IW = $clog2(N);
    localparam int CW = 2 * ZW;
    localparam int NW = $clog2(N * (N + 1) / 2 + 1);
    localparam int NCAND = N * (N + 1) / 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*ZW-1:0]   molecular_structure;
    logic              struct_valid;
    logic              struct_ready;
    logic              term_valid;
    logic              term_ready;
    logic [IW-1:0]     term_i;
    logic [IW-1:0]     term_j;
    logic [CW-1:0]     term_coef;
    logic [NW-1:0]     term_count;
    logic              hamiltonian_ready;
    logic              empty_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int i;
        int j;
        int coef;
    } term_t;

    term_t exp_q[$];

    hamiltonian_term_builder #(.N_SITES(N), .Z_W(ZW)) dut (
        .clk(clk),
        .reset(reset),
        .molecular_structure(molecular_structure),
        .struct_valid(struct_valid),
        .struct_ready(struct_ready),
        .term_valid(term_valid),
        .term_ready(term_ready),
        .term_i(term_i),
        .term_j(term_j),
        .term_coef(term_coef),
        .term_count(term_count),
        .hamiltonian_ready(hamiltonian_ready),
        .empty_err(empty_err)
    );

    always #5 clk = ~clk;

    function automatic void build_model(input logic [N*ZW-1:0] s);
        int z[N];
        term_t t;
        exp_q.delete();
        for (int k = 0; k < N; k++) z[k] = int'(s[k*ZW +: ZW]);
        for (int i = 0; i < N; i++) begin
            for (int j = i; j < N; j++) begin
                if (z[i] != 0 && z[j] != 0) begin
                    t.i = i;
                    t.j = j;
                    t.coef = (i == j) ? z[i] : z[i] * z[j];
                    exp_q.push_back(t);
                end
            end
        end
    endfunction

    // mode 0: always ready; 1: random ready; 2: hold term #stall_idx for 3 cycles
    task automatic run_structure(input logic [N*ZW-1:0] s, input int mode, input int stall_idx,
                                 output int done_edge, output int n_terms);
        int e, stalls, popped, stall_cnt;
        bit done, rdy;
        term_t h;
        build_model(s);
        n_terms = exp_q.size();
        @(negedge clk);
        n_cmp++;
        if (struct_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL struct_ready_before_accept: got %b want 1", struct_ready);
        end
        molecular_structure = s;
        struct_valid = 1'b1;
        @(negedge clk);
        struct_valid = 1'b0;
        e = 0; done = 1'b0; popped = 0; stalls = 0; stall_cnt = 0; done_edge = -1;
        while (!done && e < 400) begin
            if (hamiltonian_ready === 1'b1) begin
                done = 1'b1;
                done_edge = e;
            end else begin
                n_cmp++;
                if (term_count !== NW'(popped)) begin
                    n_bad++;
                    $display("FAIL term_count_running: got %0d want %0d at e=%0d", term_count, popped, e);
                end
                if (term_valid === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_term: got (%0d,%0d,%0d) want none", term_i, term_j, term_coef);
                    end else begin
                        h = exp_q[0];
                        if (term_i !== IW'(h.i) || term_j !== IW'(h.j) || term_coef !== CW'(h.coef)) begin
                            n_bad++;
                            $display("FAIL term_value: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                     term_i, term_j, term_coef, h.i, h.j, h.coef);
                        end
                    end
                    case (mode)
                        0: rdy = 1'b1;
                        1: rdy = ($urandom_range(0, 3) != 0);
                        2: rdy = !(popped == stall_idx && stall_cnt < 3);
                        default: rdy = 1'b1;
                    endcase
                    term_ready = rdy;
                    if (rdy) begin
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        popped++;
                    end else begin
                        stalls++;
                        stall_cnt++;
                    end
                end else begin
                    term_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                e++;
            end
        end
        n_cmp++;
        if (!done || done_edge != NCAND + stalls) begin
            n_bad++;
            $display("FAIL done_edge: got %0d want %0d", done_edge, NCAND + stalls);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL terms_missing: got %0d left want 0", exp_q.size());
        end
        n_cmp++;
        if (term_count !== NW'(n_terms) || term_valid !== 1'b0 || struct_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL done_state: got cnt=%0d tv=%b sr=%b want cnt=%0d tv=0 sr=1",
                     term_count, term_valid, struct_ready, n_terms);
        end
        term_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        molecular_structure = '0;
        struct_valid = 1'b0;
        term_ready = 1'b0;
        #3;
        n_cmp++;
        if (struct_ready !== 1'b1 || term_valid !== 1'b0 || term_i !== '0 || term_j !== '0 ||
            term_coef !== '0 || term_count !== '0 || hamiltonian_ready !== 1'b0 || empty_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got sr=%b tv=%b i=%0d j=%0d c=%0d cnt=%0d hr=%b ee=%b want 1,0,0,0,0,0,0,0",
                     struct_ready, term_valid, term_i, term_j, term_coef, term_count, hamiltonian_ready, empty_err);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (struct_ready !== 1'b1 || term_valid !== 1'b0 || hamiltonian_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got sr=%b tv=%b hr=%b want 1,0,0", struct_ready, term_valid, hamiltonian_ready);
        end
    endtask

    task automatic test_basic();
        int de, nt;
        run_structure({8'd1, 8'd2, 8'd0, 8'd3}, 0, 0, de, nt);
        n_cmp++;
        if (de != 10 || term_count !== NW'(6)) begin
            n_bad++;
            $display("FAIL basic_done: got edge=%0d cnt=%0d want edge=10 cnt=6", de, term_count);
        end
    endtask

    task automatic test_backpressure();
        int de, nt;
        run_structure({8'd1, 8'd2, 8'd0, 8'd3}, 2, 1, de, nt);
        n_cmp++;
        if (de != 13) begin
            n_bad++;
            $display("FAIL backpressure_done: got edge=%0d want 13", de);
        end
    endtask

    task automatic test_saturated();
        int de, nt;
        build_model({4{8'd255}});
        n_cmp++;
        if (exp_q[1].coef != 65025) begin
            n_bad++;
            $display("FAIL model_sat_coef: got %0d want 65025", exp_q[1].coef);
        end
        run_structure({4{8'd255}}, 1, 0, de, nt);
        n_cmp++;
        if (term_count !== NW'(10)) begin
            n_bad++;
            $display("FAIL saturated_count: got %0d want 10", term_count);
        end
    endtask

    task automatic test_back_to_back();
        int de, nt;
        n_cmp++;
        if (hamiltonian_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_precondition: got hr=%b want 1", hamiltonian_ready);
        end
        run_structure({8'd0, 8'd0, 8'd1, 8'd1}, 0, 0, de, nt);
        n_cmp++;
        if (term_count !== NW'(3) || de != 10) begin
            n_bad++;
            $display("FAIL b2b_result: got cnt=%0d edge=%0d want cnt=3 edge=10", term_count, de);
        end
    endtask

    task automatic test_empty();
        @(negedge clk);
        molecular_structure = '0;
        struct_valid = 1'b1;
        @(negedge clk);
        struct_valid = 1'b0;
        n_cmp++;
        if (empty_err !== 1'b1 || term_valid !== 1'b0 || hamiltonian_ready !== 1'b0 ||
            struct_ready !== 1'b1 || term_count !== '0) begin
            n_bad++;
            $display("FAIL empty_pulse: got ee=%b tv=%b hr=%b sr=%b cnt=%0d want 1,0,0,1,0",
                     empty_err, term_valid, hamiltonian_ready, struct_ready, term_count);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (empty_err !== 1'b0 || term_valid !== 1'b0 || hamiltonian_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL empty_after: got ee=%b tv=%b hr=%b want 0,0,0", empty_err, term_valid, hamiltonian_ready);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int cyc, de, nt;
        @(negedge clk);
        molecular_structure = {8'd1, 8'd2, 8'd0, 8'd3};
        struct_valid = 1'b1;
        term_ready = 1'b1;
        @(negedge clk);
        struct_valid = 1'b0;
        cyc = 0;
        while (term_count !== NW'(2) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (term_count !== NW'(2)) begin
            n_bad++;
            $display("FAIL mid_scan_reach: got cnt=%0d want 2", term_count);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (term_valid !== 1'b0 || term_count !== '0 || hamiltonian_ready !== 1'b0 || struct_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got tv=%b cnt=%0d hr=%b sr=%b want 0,0,0,1",
                     term_valid, term_count, hamiltonian_ready, struct_ready);
        end
        term_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_structure({8'd1, 8'd2, 8'd0, 8'd3}, 1, 0, de, nt);
    endtask

    task automatic test_random();
        logic [N*ZW-1:0] s;
        int de, nt;
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < N; k++) begin
                s[k*ZW +: ZW] = ($urandom_range(0, 9) < 3) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            if (s == '0) s[ZW-1:0] = 8'd7;
            run_structure(s, 1, 0, de, nt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturated();
        test_back_to_back();
        test_empty();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
